// File: rtl/stopwatch_upcounter_4d.sv
// Four-digit BCD mm:ss up-counting stopwatch with built-in prescaler and run-control FSM.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_upcounter_4d #(
    parameter int  TICK_DIV      = 100_000_000,
    localparam int BCD_BIT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_stop,
    input  logic                     clear,
    input  logic                     lap,
    output logic [BCD_BIT_WIDTH-1:0] digit0,
    output logic [BCD_BIT_WIDTH-1:0] digit1,
    output logic [BCD_BIT_WIDTH-1:0] digit2,
    output logic [BCD_BIT_WIDTH-1:0] digit3,
    output logic                     running,
    output logic                     done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0][BCD_BIT_WIDTH-1:0] count_t;

    localparam count_t COUNT_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

    state_t          state_q, state_d;
    logic   [PW-1:0] pcnt_q, pcnt_d;
    count_t          cnt_q, cnt_d, cnt_inc;
    count_t          disp;
    logic            tick;

    always_comb begin
        // Ripple-carry BCD increment; digit3 never wraps since 59:59 saturates.
        cnt_inc = cnt_q;
        if (cnt_q[0] == 4'd9) begin
            cnt_inc[0] = 4'd0;
            if (cnt_q[1] == 4'd5) begin
                cnt_inc[1] = 4'd0;
                if (cnt_q[2] == 4'd9) begin
                    cnt_inc[2] = 4'd0;
                    cnt_inc[3] = cnt_q[3] + 4'd1;
                end else begin
                    cnt_inc[2] = cnt_q[2] + 4'd1;
                end
            end else begin
                cnt_inc[1] = cnt_q[1] + 4'd1;
            end
        end else begin
            cnt_inc[0] = cnt_q[0] + 4'd1;
        end
    end

    assign tick = (pcnt_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A pause edge suppresses the wrap so no increment lands on it.
                    if (start_stop) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        pcnt_d = '0;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == COUNT_MAX) state_d = ST_DONE;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic   hold_q, hold_d;
    count_t held_q, held_d;

    always_comb begin
        hold_d = hold_q;
        held_d = held_q;
        if (clear || state_d == ST_IDLE || state_d == ST_DONE) begin
            hold_d = 1'b0;
        end else if (lap && !start_stop &&
                     (state_q == ST_RUN || state_q == ST_PAUSE)) begin
            hold_d = !hold_q;
            if (!hold_q) held_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
            held_q <= '0;
        end else begin
            hold_q <= hold_d;
            held_q <= held_d;
        end
    end

    assign disp = hold_q ? held_q : cnt_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = cnt_q;
`endif

    assign digit0  = disp[0];
    assign digit1  = disp[1];
    assign digit2  = disp[2];
    assign digit3  = disp[3];
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_stopwatch_upcounter_4d.sv
// Directed self-checking bench: one instance with TICK_DIV=4, one with TICK_DIV=2, shared stimulus.
// Lap checks follow STOPWATCH_LAP_EN; without it lap must be ignored.
module tb_stopwatch_upcounter_4d;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;

    logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
    logic       a_run, a_done, b_run, b_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_upcounter_4d #(.TICK_DIV(4)) u_a (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .digit0(a_d0), .digit1(a_d1), .digit2(a_d2), .digit3(a_d3),
        .running(a_run), .done(a_done)
    );

    stopwatch_upcounter_4d #(.TICK_DIV(2)) u_b (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .digit0(b_d0), .digit1(b_d1), .digit2(b_d2), .digit3(b_d3),
        .running(b_run), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int sec);
        int m, s;
        m = sec / 60;
        s = sec % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] a_cnt();
        return {a_d3, a_d2, a_d1, a_d0};
    endfunction

    function automatic logic [15:0] b_cnt();
        return {b_d3, b_d2, b_d1, b_d0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; step(1); lap = 1'b0;
    endtask

    initial begin
        // Reset and idle
        step(1);
        rst = 1'b1; step(2); rst = 1'b0;
        chk("rst_digits", a_cnt(), 16'h0000);
        chk("rst_running", a_run, 0);
        chk("rst_done", a_done, 0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_hold", a_cnt(), 16'h0000);
        end

        // Counting, TICK_DIV=4: one increment every 4 cycles
        pulse_start();
        chk("start_running", a_run, 1);
        for (int k = 1; k <= 40; k++) begin
            step(1);
            chk("count_a", a_cnt(), bcd(k / 4));
        end
        chk("count_00_10", a_cnt(), 16'h0010);

        // Pause and resume
        pulse_clear();
        chk("clear_idle", a_run, 0);
        pulse_start();
        step(6);
        chk("pre_pause", a_cnt(), 16'h0001);
        pulse_start();
        chk("pause_running", a_run, 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("paused_hold", a_cnt(), 16'h0001);
            chk("paused_run", a_run, 0);
        end
        pulse_start();
        chk("resume_running", a_run, 1);
        chk("resume_cnt", a_cnt(), 16'h0001);
        step(1);
        chk("resume_plus1", a_cnt(), 16'h0001);
        step(1);
        chk("resume_plus2", a_cnt(), 16'h0002);

        // Carry chain and saturation, TICK_DIV=2
        pulse_clear();
        pulse_start();
        for (int k = 1; k < 7198; k++) begin
            step(1);
            chk("carry_b", b_cnt(), bcd(k / 2));
            if (k == 7197) chk("not_done_yet", b_done, 0);
        end
        step(1);
        chk("sat_59_59", b_cnt(), 16'h5959);
        chk("sat_done", b_done, 1);
        chk("sat_running", b_run, 0);
        step(10);
        chk("sat_frozen", b_cnt(), 16'h5959);
        pulse_start();
        chk("sat_ss_ignored", b_cnt(), 16'h5959);
        chk("sat_ss_done", b_done, 1);
        chk("sat_ss_run", b_run, 0);
        pulse_clear();
        chk("sat_clear_cnt", b_cnt(), 16'h0000);
        chk("sat_clear_done", b_done, 0);
        chk("sat_clear_run", b_run, 0);

        // Clear on the same edge as the wrap to 59:59
        pulse_start();
        step(7197);
        chk("pre_wrap_cnt", b_cnt(), 16'h5958);
        pulse_clear();
        chk("wrapclr_cnt", b_cnt(), 16'h0000);
        chk("wrapclr_done", b_done, 0);

        // Priority: clear with start_stop while running at 01:23
        pulse_clear();
        pulse_start();
        step(332);
        chk("prio_01_23", a_cnt(), 16'h0123);
        clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
        chk("prio_cnt", a_cnt(), 16'h0000);
        chk("prio_running", a_run, 0);
        step(5);
        chk("prio_idle_stays", a_cnt(), 16'h0000);

        // Lap hold
        pulse_clear();
        pulse_start();
        step(12);
        chk("lap_pre", a_cnt(), 16'h0003);
        pulse_lap();
`ifdef STOPWATCH_LAP_EN
        for (int k = 14; k <= 32; k++) begin
            step(1);
            chk("lap_hold", a_cnt(), 16'h0003);
            chk("lap_running", a_run, 1);
        end
        pulse_lap();
        chk("lap_release", a_cnt(), 16'h0008);
`else
        for (int k = 14; k <= 32; k++) begin
            step(1);
            chk("lap_ignored", a_cnt(), bcd(k / 4));
        end
        pulse_lap();
        chk("lap_ignored_end", a_cnt(), 16'h0008);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
